// File: rtl/regfile_pkg.sv
// Shared types and sizes for the 16x16 register file write arbiter.
package regfile_pkg;

    localparam int unsigned NUM_REGS   = 16;
    localparam int unsigned ADDR_W     = 4;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned STARVE_MAX = 3;
    localparam int unsigned STARVE_W   = 2;

    typedef logic [ADDR_W-1:0] reg_addr_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STAGED = 1'b1
    } stage_state_e;

endpackage

// File: rtl/regfile_addr_decoder.sv
// Address to one-hot register select decoder.
//   en_i      : when low, all select lines are low
//   addr_i    : register address
//   onehot_o  : one-hot select, bit addr_i set when enabled
module regfile_addr_decoder
    import regfile_pkg::*;
(
    input  logic                en_i,
    input  reg_addr_t           addr_i,
    output logic [NUM_REGS-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[addr_i] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter, write staging and read decode for the 16x16 register file.
//   clk, rst                       : clock, synchronous active-high reset
//   wb_req/wb_addr/wb_data/wb_gnt  : writeback write requester
//   aux_req/aux_addr/aux_data/aux_gnt : auxiliary write requester
//   rd_addr1, rd_addr2             : read port addresses
//   write_en, write_data           : staged write driven to the cells
//   read_en1, read_en2             : one-hot read selects
//   bypass1, bypass2, bypass_data  : read-after-staged-write forwarding
module regfile_write_arbiter
    import regfile_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                wb_req,
    input  reg_addr_t           wb_addr,
    input  logic [DATA_W-1:0]   wb_data,
    output logic                wb_gnt,
    input  logic                aux_req,
    input  reg_addr_t           aux_addr,
    input  logic [DATA_W-1:0]   aux_data,
    output logic                aux_gnt,
    input  reg_addr_t           rd_addr1,
    input  reg_addr_t           rd_addr2,
    output logic [NUM_REGS-1:0] write_en,
    output logic [DATA_W-1:0]   write_data,
    output logic [NUM_REGS-1:0] read_en1,
    output logic [NUM_REGS-1:0] read_en2,
    output logic                bypass1,
    output logic                bypass2,
    output logic [DATA_W-1:0]   bypass_data
);

    stage_state_e          state_q, state_d;
    reg_addr_t             staged_addr_q, staged_addr_d;
    logic [DATA_W-1:0]     staged_data_q, staged_data_d;
    logic [STARVE_W-1:0]   starve_q, starve_d;
    logic                  staged_vld;

    // Grants: WB by default; AUX when WB is idle or AUX has starved long enough.
    always_comb begin
        aux_gnt = !rst && aux_req && (!wb_req || (starve_q == STARVE_W'(STARVE_MAX)));
        wb_gnt  = !rst && wb_req && !aux_gnt;
    end

    // Next-state: staging FSM and AUX starvation counter.
    always_comb begin
        state_d       = ST_IDLE;
        staged_addr_d = staged_addr_q;
        staged_data_d = staged_data_q;
        starve_d      = starve_q;

        if (wb_gnt) begin
            state_d       = ST_STAGED;
            staged_addr_d = wb_addr;
            staged_data_d = wb_data;
        end else if (aux_gnt) begin
            state_d       = ST_STAGED;
            staged_addr_d = aux_addr;
            staged_data_d = aux_data;
        end

        if (!aux_req || aux_gnt) begin
            starve_d = '0;
        end else if (starve_q != STARVE_W'(STARVE_MAX)) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            staged_addr_q <= '0;
            staged_data_q <= '0;
            starve_q      <= '0;
        end else begin
            state_q       <= state_d;
            staged_addr_q <= staged_addr_d;
            staged_data_q <= staged_data_d;
            starve_q      <= starve_d;
        end
    end

    // Gating with rst drops a write still staged when reset arrives; R0 never writes.
    assign staged_vld = !rst && (state_q == ST_STAGED) && (staged_addr_q != '0);

    assign write_data  = rst ? '0 : staged_data_q;
    assign bypass_data = write_data;
    assign bypass1     = staged_vld && (rd_addr1 == staged_addr_q);
    assign bypass2     = staged_vld && (rd_addr2 == staged_addr_q);

    regfile_addr_decoder u_wr_dec (
        .en_i     (staged_vld),
        .addr_i   (staged_addr_q),
        .onehot_o (write_en)
    );

    regfile_addr_decoder u_rd1_dec (
        .en_i     (1'b1),
        .addr_i   (rd_addr1),
        .onehot_o (read_en1)
    );

    regfile_addr_decoder u_rd2_dec (
        .en_i     (1'b1),
        .addr_i   (rd_addr2),
        .onehot_o (read_en2)
    );

endmodule
